// File: rtl/tone_sequencer.sv
// Tone sequencer: steps a square-wave divider through a {div, dur} table and pulses Done at the end.
// Optional build macro TONE_SEQ_LOOP_EN replays the table from step 0 instead of finishing.
module tone_sequencer #(
  parameter int STEPS    = 8,
  parameter int DIV_W    = 26,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 100000
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic                     LoadEn,
  input  logic [$clog2(STEPS)-1:0] LoadAddr,
  input  logic [DIV_W-1:0]         LoadDiv,
  input  logic [DUR_W-1:0]         LoadDur,
  output logic                     ToneOut,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(STEPS)-1:0] StepIdx
);

  localparam int IDX_W = $clog2(STEPS);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // state   | meaning
  // IDLE    | waiting for Start, table writable
  // LOAD    | latch current entry, clear counters
  // RUN     | tone divider and duration timer running
  // DONE    | one-cycle completion pulse
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } stateT;

  stateT            state, stateNext;
  logic [IDX_W-1:0] stepIdx, stepIdxNext;

  logic [DIV_W-1:0] tblDiv [STEPS];
  logic [DUR_W-1:0] tblDur [STEPS];

  logic [DIV_W-1:0] curDiv, toneCnt;
  logic [DUR_W-1:0] curDur, durCnt;
  logic [PRE_W-1:0] preCnt;
  logic             toneReg;

  logic tick, stepEnd, lastStep, entryEmpty;

  assign tick       = (state == ST_RUN) && (preCnt == PRE_LAST);
  assign stepEnd    = tick && ((durCnt + DUR_W'(1)) == curDur);
  assign lastStep   = (stepIdx == LAST_IDX);
  assign entryEmpty = (tblDur[stepIdx] == '0);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= ST_IDLE;
      stepIdx <= '0;
    end else begin
      state   <= stateNext;
      stepIdx <= stepIdxNext;
    end
  end

  always_comb begin
    stateNext   = state;
    stepIdxNext = stepIdx;
    case (state)
      ST_IDLE: begin
        if (Start && !Stop) begin
          stateNext   = ST_LOAD;
          stepIdxNext = '0;
        end
      end
      ST_LOAD: begin
        if (Stop) begin
          stateNext   = ST_IDLE;
          stepIdxNext = '0;
        end else if (entryEmpty) begin
`ifdef TONE_SEQ_LOOP_EN
          // an end marker past entry 0 wraps playback; only an empty entry 0 finishes
          if (stepIdx != '0) begin
            stateNext   = ST_LOAD;
            stepIdxNext = '0;
          end else begin
            stateNext = ST_DONE;
          end
`else
          stateNext = ST_DONE;
`endif
        end else begin
          stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          stateNext   = ST_IDLE;
          stepIdxNext = '0;
        end else if (stepEnd) begin
          stateNext = ST_LOAD;
          if (!lastStep) begin
            stepIdxNext = stepIdx + IDX_W'(1);
          end else begin
`ifdef TONE_SEQ_LOOP_EN
            stepIdxNext = '0;
`else
            stateNext = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state == ST_LOAD) || (state == ST_RUN);
    Done    = (state == ST_DONE);
    ToneOut = (state == ST_RUN) && toneReg;
    StepIdx = stepIdx;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < STEPS; i++) begin
        tblDiv[i] <= '0;
        tblDur[i] <= '0;
      end
    end else if (LoadEn && !Busy && (int'(LoadAddr) < STEPS)) begin
      tblDiv[LoadAddr] <= LoadDiv;
      tblDur[LoadAddr] <= LoadDur;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      curDiv  <= '0;
      curDur  <= '0;
      toneCnt <= '0;
      preCnt  <= '0;
      durCnt  <= '0;
      toneReg <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          curDiv  <= tblDiv[stepIdx];
          curDur  <= tblDur[stepIdx];
          toneCnt <= '0;
          preCnt  <= '0;
          durCnt  <= '0;
          toneReg <= 1'b0;
        end
        ST_RUN: begin
          // half period is div+1 clocks; div of zero is a rest
          if (curDiv == '0) begin
            toneCnt <= '0;
            toneReg <= 1'b0;
          end else if (toneCnt == curDiv) begin
            toneCnt <= '0;
            toneReg <= ~toneReg;
          end else begin
            toneCnt <= toneCnt + DIV_W'(1);
          end
          if (tick) begin
            preCnt <= '0;
            durCnt <= durCnt + DUR_W'(1);
          end else begin
            preCnt <= preCnt + PRE_W'(1);
          end
        end
        default: begin
          toneCnt <= '0;
          preCnt  <= '0;
          durCnt  <= '0;
          toneReg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: expected per-cycle outputs are derived from the step table as a timeline.
`timescale 1ns/1ps
module tb_tone_sequencer;

  localparam int STEPS    = 4;
  localparam int DIV_W    = 6;
  localparam int DUR_W    = 4;
  localparam int TICK_DIV = 4;
  localparam int IDX_W    = $clog2(STEPS);
`ifdef TONE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             Start = 1'b0;
  logic             Stop = 1'b0;
  logic             LoadEn = 1'b0;
  logic [IDX_W-1:0] LoadAddr = '0;
  logic [DIV_W-1:0] LoadDiv = '0;
  logic [DUR_W-1:0] LoadDur = '0;
  logic             ToneOut, Busy, Done;
  logic [IDX_W-1:0] StepIdx;

  int checks = 0;
  int errors = 0;

  int mDiv [STEPS];
  int mDur [STEPS];

  typedef struct {
    bit busy;
    bit done;
    bit tone;
    int idx;   // -1: not checked
  } expT;
  expT expQ[$];

  tone_sequencer #(
    .STEPS(STEPS), .DIV_W(DIV_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadDiv(LoadDiv), .LoadDur(LoadDur),
    .ToneOut(ToneOut), .Busy(Busy), .Done(Done), .StepIdx(StepIdx)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setEntry(input int a, input int d, input int u);
    LoadEn = 1'b1;
    LoadAddr = IDX_W'(a);
    LoadDiv = DIV_W'(d);
    LoadDur = DUR_W'(u);
    tick();
    LoadEn = 1'b0;
    mDiv[a] = d;
    mDur[a] = u;
  endtask

  task automatic setAll(input int d, input int u);
    for (int i = 0; i < STEPS; i++) setEntry(i, d, u);
  endtask

  // Timeline: one LOAD cycle per visited entry, dur*TICK_DIV RUN cycles, DONE at the end.
  function automatic void buildTrace(input int maxLen);
    int i;
    bit t;
    i = 0;
    expQ.delete();
    while (expQ.size() < maxLen) begin
      expQ.push_back('{1'b1, 1'b0, 1'b0, i});
      if (mDur[i] == 0) begin
        if (LOOP && i != 0) begin
          i = 0;
          continue;
        end
        expQ.push_back('{1'b0, 1'b1, 1'b0, -1});
        break;
      end
      for (int j = 0; j < mDur[i] * TICK_DIV; j++) begin
        t = (mDiv[i] != 0) && (((j / (mDiv[i] + 1)) % 2) == 1);
        expQ.push_back('{1'b1, 1'b0, t, i});
      end
      if (i == STEPS - 1) begin
        if (LOOP) i = 0;
        else begin
          expQ.push_back('{1'b0, 1'b1, 1'b0, -1});
          break;
        end
      end else begin
        i++;
      end
    end
  endfunction

  task automatic play(input string tag, input int maxLen, input int stopAt, input bit startAtDone,
                      input bit poke);
    int stopN;
    buildTrace(maxLen);
    stopN = stopAt;
    if (stopN < 0 && !expQ[expQ.size()-1].done) stopN = expQ.size() - 1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int n = 0; n < expQ.size(); n++) begin
      if (n > 0) tick();
      chk({tag, ".busy"}, 32'(Busy), 32'(expQ[n].busy));
      chk({tag, ".done"}, 32'(Done), 32'(expQ[n].done));
      chk({tag, ".tone"}, 32'(ToneOut), 32'(expQ[n].tone));
      if (expQ[n].idx >= 0) chk({tag, ".idx"}, 32'(StepIdx), 32'(expQ[n].idx));
      if (poke && n >= 1 && n <= 2 && expQ[n].busy && expQ[n+1].busy) begin
        LoadEn = 1'b1;
        LoadAddr = '0;
        LoadDiv = DIV_W'(mDiv[0] + 7);
        LoadDur = DUR_W'(mDur[0] + 5);
      end else begin
        LoadEn = 1'b0;
      end
      if (n == stopN) begin
        LoadEn = 1'b0;
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        chk({tag, ".stopBusy"}, 32'(Busy), 32'd0);
        chk({tag, ".stopTone"}, 32'(ToneOut), 32'd0);
        chk({tag, ".stopIdx"}, 32'(StepIdx), 32'd0);
        for (int k = 0; k < 3; k++) begin
          chk({tag, ".stopDone"}, 32'(Done), 32'd0);
          tick();
        end
        return;
      end
      if (expQ[n].done && startAtDone) Start = 1'b1;
    end
    LoadEn = 1'b0;
    tick();
    Start = 1'b0;
    chk({tag, ".idleBusy"}, 32'(Busy), 32'd0);
    chk({tag, ".idleDone"}, 32'(Done), 32'd0);
    chk({tag, ".idleTone"}, 32'(ToneOut), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < STEPS; i++) begin
      mDiv[i] = 0;
      mDur[i] = 0;
    end
    #2 Rst = 1'b0;
    #2;
    chk("rst.busy", 32'(Busy), 32'd0);
    chk("rst.done", 32'(Done), 32'd0);
    chk("rst.tone", 32'(ToneOut), 32'd0);
    chk("rst.idx", 32'(StepIdx), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #3 Rst = 1'b1;
    tick();

    // empty table, Start held into the DONE cycle must be ignored
    play("empty", 80, -1, 1'b1, 1'b0);

    setEntry(0, 2, 3);
    play("single", 60, -1, 1'b0, 1'b0);

    setAll(1, 1);
    play("allOnes", 80, -1, 1'b0, 1'b0);

    setAll(0, 0);
    setEntry(0, 0, 2);
    play("rest", 80, -1, 1'b0, 1'b0);

    setEntry(0, 1, 1);
    setEntry(1, 2, 1);
    setEntry(2, 4, 0);
    play("twoStep", 60, -1, 1'b0, 1'b0);

    // stop during step 1 with table writes attempted while busy, then replay
    setEntry(0, 3, 2);
    setEntry(1, 1, 2);
    setEntry(2, 2, 1);
    setEntry(3, 0, 0);
    play("stopMid", 200, 13, 1'b0, 1'b1);
    play("replay", 60, -1, 1'b0, 1'b0);

    Start = 1'b1;
    Stop = 1'b1;
    tick();
    chk("startStop.busy", 32'(Busy), 32'd0);
    tick();
    chk("startStop.busy2", 32'(Busy), 32'd0);
    Start = 1'b0;
    Stop = 1'b0;
    tick();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < STEPS; i++)
        setEntry(i, int'($urandom_range(0, 5)),
                 ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3)));
      play($sformatf("rand%0d", r), 80, -1, 1'b0, 1'b0);
    end

    // asynchronous reset while the tone is high
    setAll(0, 0);
    setEntry(0, 1, 3);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    chk("arst.toneHigh", 32'(ToneOut), 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("arst.busy", 32'(Busy), 32'd0);
    chk("arst.done", 32'(Done), 32'd0);
    chk("arst.tone", 32'(ToneOut), 32'd0);
    chk("arst.idx", 32'(StepIdx), 32'd0);
    #3 Rst = 1'b1;
    for (int i = 0; i < STEPS; i++) begin
      mDiv[i] = 0;
      mDur[i] = 0;
    end
    tick();
    chk("arst.noDone", 32'(Done), 32'd0);
    play("afterRst", 80, -1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
